// File: rtl/ipc_tokenizer.sv
// Splits a valid/ready ASCII byte stream into whitespace/comma-delimited tokens for the IPC dispatcher.
// Optional build macro TOKENIZER_LOWERCASE_EN folds A-Z to lowercase before storage.
module ipc_tokenizer #(
    parameter int TOKEN_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             RX_DATA,
    input  logic                   RX_VALID,
    output logic                   RX_READY,
    output logic [TOKEN_WIDTH-1:0] TOKEN,
    output logic                   TOKEN_EOL,
    output logic                   START,
    input  logic                   IDLE,
    output logic                   OVERFLOW
);

    localparam int MAX_CHARS = TOKEN_WIDTH / 8;
    localparam int LEN_W     = $clog2(MAX_CHARS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);

    typedef enum logic [1:0] {
        S_SKIP  = 2'd0,
        S_ACCUM = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [TOKEN_WIDTH-1:0] token_q;
    logic                   eol_q;
    logic                   start_q;
    logic                   ovf_pulse_q;
    logic [LEN_W-1:0]       len_q;
    logic                   ovf_q;

    logic                   rx_fire;
    logic                   rx_delim;
    logic                   rx_eol;
    logic [7:0]             rx_char;
    logic [TOKEN_WIDTH+7:0] token_cat;
    logic [TOKEN_WIDTH-1:0] token_shift_d;
    logic [TOKEN_WIDTH-1:0] token_first_d;

    function automatic logic is_delim(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h09) || (b == 8'h2C) ||
               (b == 8'h0D) || (b == 8'h0A);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

`ifdef TOKENIZER_LOWERCASE_EN
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) ? (b + 8'h20) : b;
    endfunction

    assign rx_char = fold_case(RX_DATA);
`else
    assign rx_char = RX_DATA;
`endif

    // Delimiter classification always looks at the raw byte, never the folded one.
    assign rx_delim = is_delim(RX_DATA);
    assign rx_eol   = is_eol(RX_DATA);

    assign RX_READY = (state_q == S_SKIP) || (state_q == S_ACCUM);
    assign rx_fire  = RX_VALID && RX_READY;

    // Concatenate-then-truncate keeps the shift legal even for an 8-bit token.
    assign token_cat     = {token_q, rx_char};
    assign token_shift_d = token_cat[TOKEN_WIDTH-1:0];
    assign token_first_d = TOKEN_WIDTH'(rx_char);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_SKIP;
            token_q     <= '0;
            eol_q       <= 1'b0;
            start_q     <= 1'b0;
            ovf_pulse_q <= 1'b0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ovf_pulse_q <= 1'b0;
            case (state_q)
                S_SKIP: begin
                    if (rx_fire && !rx_delim) begin
                        token_q <= token_first_d;
                        len_q   <= LEN_W'(1);
                        ovf_q   <= 1'b0;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (rx_fire) begin
                        if (rx_delim) begin
                            if (ovf_q) begin
                                ovf_pulse_q <= 1'b1;
                                state_q     <= S_SKIP;
                            end else begin
                                eol_q   <= rx_eol;
                                state_q <= S_ISSUE;
                            end
                        end else if (len_q < MAX_LEN) begin
                            token_q <= token_shift_d;
                            len_q   <= len_q + LEN_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (IDLE) begin
                        start_q <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // IDLE may still reflect the pre-START dispatcher state while START is high.
                    start_q <= 1'b0;
                    if (!start_q && IDLE) begin
                        state_q <= S_SKIP;
                    end
                end
                default: begin
                    state_q <= S_SKIP;
                end
            endcase
        end
    end

    assign TOKEN     = token_q;
    assign TOKEN_EOL = eol_q;
    assign START     = start_q;
    assign OVERFLOW  = ovf_pulse_q;

endmodule

// File: tb/tb_ipc_tokenizer.sv
// Directed bench for ipc_tokenizer: tokens, delimiters, IDLE handshake, overflow, reset, case folding.
module tb_ipc_tokenizer;

    localparam int TW = 256;

    logic          clk;
    logic          resetn;
    logic [7:0]    RX_DATA;
    logic          RX_VALID;
    logic          RX_READY;
    logic [TW-1:0] TOKEN;
    logic          TOKEN_EOL;
    logic          START;
    logic          IDLE;
    logic          OVERFLOW;

    int n_tests;
    int n_fail;
    int n_start;
    int n_ovf;
    logic [TW-1:0] tok_log [0:63];
    logic          eol_log [0:63];

    ipc_tokenizer #(.TOKEN_WIDTH(TW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .TOKEN    (TOKEN),
        .TOKEN_EOL(TOKEN_EOL),
        .START    (START),
        .IDLE     (IDLE),
        .OVERFLOW (OVERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every START and OVERFLOW cycle as seen just before the edge.
    always @(posedge clk) begin
        if (START) begin
            if (n_start < 64) begin
                tok_log[n_start] = TOKEN;
                eol_log[n_start] = TOKEN_EOL;
            end
            n_start = n_start + 1;
        end
        if (OVERFLOW) n_ovf = n_ovf + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        t = 0;
        while (!RX_READY && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: RX_READY=%0b after %0d cycles, required 1", RX_READY, t);
        end
        @(negedge clk);
        RX_VALID = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        IDLE     = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++; if (START !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b required 0", START); end
        n_tests++; if (TOKEN !== '0) begin n_fail++; $display("FAIL reset_token: got %0h required 0", TOKEN); end
        n_tests++; if (TOKEN_EOL !== 1'b0) begin n_fail++; $display("FAIL reset_eol: got %0b required 0", TOKEN_EOL); end
        n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b required 0", OVERFLOW); end
        n_tests++; if (RX_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", RX_READY); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int s0, o0;
        s0 = n_start; o0 = n_ovf;
        IDLE = 1'b1;
        send_str("led\n");
        n_tests++; if (START !== 1'b0) begin n_fail++; $display("FAIL single_start_n1: got %0b required 0", START); end
        n_tests++; if (RX_READY !== 1'b0) begin n_fail++; $display("FAIL single_ready_issue: got %0b required 0", RX_READY); end
        @(negedge clk);
        n_tests++; if (START !== 1'b1) begin n_fail++; $display("FAIL single_start_n2: got %0b required 1", START); end
        n_tests++; if (TOKEN !== TW'(24'h6C6564)) begin n_fail++; $display("FAIL single_token: got %0h required 6c6564", TOKEN); end
        n_tests++; if (TOKEN_EOL !== 1'b1) begin n_fail++; $display("FAIL single_eol: got %0b required 1", TOKEN_EOL); end
        @(negedge clk);
        n_tests++; if (START !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %0b required 0", START); end
        n_tests++; if (RX_READY !== 1'b0) begin n_fail++; $display("FAIL single_ready_guard: got %0b required 0", RX_READY); end
        @(negedge clk);
        n_tests++; if (RX_READY !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %0b required 1", RX_READY); end
        settle();
        n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d required 1", n_start - s0); end
        n_tests++; if (n_ovf - o0 !== 0) begin n_fail++; $display("FAIL single_ovf: got %0d required 0", n_ovf - o0); end
    endtask

    task automatic test_multi();
        int s0;
        s0 = n_start;
        send_str("  led , on\r\n");
        settle();
        n_tests++; if (n_start - s0 !== 2) begin n_fail++; $display("FAIL multi_count: got %0d required 2", n_start - s0); end
        n_tests++; if (tok_log[s0] !== TW'(24'h6C6564)) begin n_fail++; $display("FAIL multi_tok0: got %0h required 6c6564", tok_log[s0]); end
        n_tests++; if (eol_log[s0] !== 1'b0) begin n_fail++; $display("FAIL multi_eol0: got %0b required 0", eol_log[s0]); end
        n_tests++; if (tok_log[s0+1] !== TW'(16'h6F6E)) begin n_fail++; $display("FAIL multi_tok1: got %0h required 6f6e", tok_log[s0+1]); end
        n_tests++; if (eol_log[s0+1] !== 1'b1) begin n_fail++; $display("FAIL multi_eol1: got %0b required 1", eol_log[s0+1]); end
    endtask

    task automatic test_delims();
        int s0;
        s0 = n_start;
        send_str("x\ty,z\n");
        settle();
        n_tests++; if (n_start - s0 !== 3) begin n_fail++; $display("FAIL delim_count: got %0d required 3", n_start - s0); end
        n_tests++; if (tok_log[s0] !== TW'(8'h78)) begin n_fail++; $display("FAIL delim_tok0: got %0h required 78", tok_log[s0]); end
        n_tests++; if (tok_log[s0+1] !== TW'(8'h79)) begin n_fail++; $display("FAIL delim_tok1: got %0h required 79", tok_log[s0+1]); end
        n_tests++; if (tok_log[s0+2] !== TW'(8'h7A)) begin n_fail++; $display("FAIL delim_tok2: got %0h required 7a", tok_log[s0+2]); end
        n_tests++; if (eol_log[s0+2] !== 1'b1) begin n_fail++; $display("FAIL delim_eol2: got %0b required 1", eol_log[s0+2]); end
    endtask

    task automatic test_idle_hold();
        int s0;
        int bad_rdy, bad_start;
        s0 = n_start;
        IDLE = 1'b0;
        send_str("led ");
        bad_rdy = 0; bad_start = 0;
        for (int i = 0; i < 20; i++) begin
            if (RX_READY !== 1'b0) bad_rdy++;
            if (START !== 1'b0) bad_start++;
            @(negedge clk);
        end
        n_tests++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL hold_ready: got %0d cycles high required 0", bad_rdy); end
        n_tests++; if (bad_start !== 0) begin n_fail++; $display("FAIL hold_start: got %0d cycles high required 0", bad_start); end
        IDLE = 1'b1;
        @(negedge clk);
        n_tests++; if (START !== 1'b1) begin n_fail++; $display("FAIL hold_start_rise: got %0b required 1", START); end
        n_tests++; if (TOKEN !== TW'(24'h6C6564)) begin n_fail++; $display("FAIL hold_token: got %0h required 6c6564", TOKEN); end
        IDLE = 1'b0;
        bad_rdy = 0;
        repeat (4) begin
            @(negedge clk);
            if (RX_READY !== 1'b0) bad_rdy++;
        end
        n_tests++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL hold_ready_wait: got %0d cycles high required 0", bad_rdy); end
        IDLE = 1'b1;
        @(negedge clk);
        n_tests++; if (RX_READY !== 1'b1) begin n_fail++; $display("FAIL hold_ready_back: got %0b required 1", RX_READY); end
        settle();
        n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL hold_count: got %0d required 1", n_start - s0); end
    endtask

    task automatic test_overflow();
        int s0, o0;
        logic [TW-1:0] all_a;
        all_a = {32{8'h61}};
        s0 = n_start; o0 = n_ovf;
        for (int i = 0; i < 32; i++) send_byte(8'h61);
        send_byte(8'h20);
        settle();
        n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL max_count: got %0d required 1", n_start - s0); end
        n_tests++; if (tok_log[s0] !== all_a) begin n_fail++; $display("FAIL max_token: got %0h required %0h", tok_log[s0], all_a); end
        n_tests++; if (n_ovf - o0 !== 0) begin n_fail++; $display("FAIL max_ovf: got %0d required 0", n_ovf - o0); end
        s0 = n_start;
        for (int i = 0; i < 33; i++) send_byte(8'h61);
        send_byte(8'h20);
        settle();
        n_tests++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL ovf_nostart: got %0d required 0", n_start - s0); end
        n_tests++; if (n_ovf - o0 !== 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d required 1", n_ovf - o0); end
        send_str("x ");
        settle();
        n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL ovf_after_count: got %0d required 1", n_start - s0); end
        n_tests++; if (tok_log[s0] !== TW'(8'h78)) begin n_fail++; $display("FAIL ovf_after_token: got %0h required 78", tok_log[s0]); end
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = n_start;
        send_str("le");
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_tests++; if (TOKEN !== '0) begin n_fail++; $display("FAIL rmid_token: got %0h required 0", TOKEN); end
        n_tests++; if (RX_READY !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b required 1", RX_READY); end
        settle();
        n_tests++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL rmid_nostart: got %0d required 0", n_start - s0); end
        send_str("d ");
        settle();
        n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL rmid_count: got %0d required 1", n_start - s0); end
        n_tests++; if (tok_log[s0] !== TW'(8'h64)) begin n_fail++; $display("FAIL rmid_token_d: got %0h required 64", tok_log[s0]); end
        n_tests++; if (eol_log[s0] !== 1'b0) begin n_fail++; $display("FAIL rmid_eol: got %0b required 0", eol_log[s0]); end
    endtask

    task automatic test_case();
        int s0;
        logic [TW-1:0] exp_tok;
`ifdef TOKENIZER_LOWERCASE_EN
        exp_tok = TW'(24'h6C6564);
`else
        exp_tok = TW'(24'h4C4544);
`endif
        s0 = n_start;
        send_str("LED ");
        settle();
        n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL case_count: got %0d required 1", n_start - s0); end
        n_tests++; if (tok_log[s0] !== exp_tok) begin n_fail++; $display("FAIL case_token: got %0h required %0h", tok_log[s0], exp_tok); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_start = 0;
        n_ovf   = 0;
        resetn   = 1'b0;
        IDLE     = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_delims();
        test_idle_hold();
        test_overflow();
        test_reset_mid();
        test_case();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
